// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the address select block
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_OVRD = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  // Select index width; a two-source mux still needs one bit.
  function automatic int sel_width(input int nsrc);
    return (nsrc <= 2) ? 1 : $clog2(nsrc);
  endfunction

endpackage

// File: rtl/mem_addr_select_if.sv
// rtl/mem_addr_select_if.sv - request/response bundle of the address select block
interface mem_addr_select_if
  import mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4
);
  localparam int SELW = sel_width(NSRC);

  // Requests toward the selector
  logic [SELW-1:0]       sel;
  logic [NSRC*WIDTH-1:0] src_flat;
  logic                  load;
  logic                  release_req;
  logic                  excpt_req;
  logic [WIDTH-1:0]      excpt_addr;
  logic                  excpt_ack;
  logic [1:0]            size;

  // Registered results
  logic [WIDTH-1:0]      addr_out;
  logic                  addr_valid;
  logic                  override;
  logic                  misaligned;
  logic                  sel_err;

  modport master (
    output sel, src_flat, load, release_req, excpt_req, excpt_addr, excpt_ack, size,
    input  addr_out, addr_valid, override, misaligned, sel_err
  );

  modport slave (
    input  sel, src_flat, load, release_req, excpt_req, excpt_addr, excpt_ack, size,
    output addr_out, addr_valid, override, misaligned, sel_err
  );

endinterface

// File: rtl/mem_addr_select_align_check.sv
// rtl/mem_addr_select_align_check.sv - combinational alignment decode of a held address
module align_check
  import mem_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  size_t      size,
  output logic       misaligned
);

  // Reserved size is reported through sel_err, so it never flags misalignment here.
  always_comb begin
    misaligned = 1'b0;
    unique case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr_lo[0];
      SZ_WORD: misaligned = |addr_lo;
      SZ_RSVD: misaligned = 1'b0;
      default: misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_addr_select.sv
// rtl/mem_addr_select.sv - selects and holds an address from N sources with exception override
module mem_addr_select
  import mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4
)(
  input  logic clk,
  input  logic reset_n,
  mem_addr_select_if.slave bus
);

  localparam int              SELW   = sel_width(NSRC);
  localparam logic [SELW:0]   NSRC_W = NSRC[SELW:0];

  state_t            state;
  logic [WIDTH-1:0]  addr_q;
  logic              valid_q;
  logic              ovrd_q;
  size_t             size_q;
  logic              sel_err_q;

  logic              sel_ok;
  logic [SELW-1:0]   sel_idx;
  logic [WIDTH-1:0]  src_sel;
  size_t             size_in;
  logic              misaligned_w;

  // Out-of-range indices fall back to source 0 so the mux never reads past src_flat.
  always_comb begin
    sel_ok  = ({1'b0, bus.sel} < NSRC_W);
    sel_idx = sel_ok ? bus.sel : '0;
    src_sel = bus.src_flat[int'(sel_idx)*WIDTH +: WIDTH];
    size_in = size_t'(bus.size);
  end

  // Control FSM; exception outranks load, load outranks release, OVRD waits only for ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      ovrd_q    <= 1'b0;
      size_q    <= SZ_WORD;
      sel_err_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_HOLD: begin
          if (bus.excpt_req) begin
            state   <= ST_OVRD;
            addr_q  <= bus.excpt_addr;
            valid_q <= 1'b1;
            ovrd_q  <= 1'b1;
            size_q  <= SZ_WORD;
          end else if (bus.load) begin
            state     <= ST_HOLD;
            addr_q    <= src_sel;
            valid_q   <= 1'b1;
            size_q    <= size_in;
            sel_err_q <= !sel_ok || (size_in == SZ_RSVD);
          end else if (bus.release_req && (state == ST_HOLD)) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        ST_OVRD: begin
          if (bus.excpt_ack) begin
            state  <= ST_HOLD;
            ovrd_q <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
          ovrd_q  <= 1'b0;
        end
      endcase
    end
  end

  align_check u_align_check (
    .addr_lo    (addr_q[1:0]),
    .size       (size_q),
    .misaligned (misaligned_w)
  );

  assign bus.addr_out   = addr_q;
  assign bus.addr_valid = valid_q;
  assign bus.override   = ovrd_q;
  assign bus.misaligned = misaligned_w;
  assign bus.sel_err    = sel_err_q;

endmodule

// File: tb/tb_mem_addr_select.sv
// tb/tb_mem_addr_select.sv - directed vector bench for mem_addr_select
module tb_mem_addr_select;

  localparam int WIDTH = 32;
  localparam int NSRC  = 3;

  typedef struct {
    logic        ld;
    logic        rl;
    logic        er;
    logic        ea;
    logic [1:0]  sel;
    logic [1:0]  sz;
    logic [31:0] eaddr;
    logic [31:0] x_addr;
    logic        x_valid;
    logic        x_ovrd;
    logic        x_mis;
    logic        x_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  mem_addr_select_if #(.WIDTH(WIDTH), .NSRC(NSRC)) bus ();

  mem_addr_select #(.WIDTH(WIDTH), .NSRC(NSRC)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] a, input logic v,
                       input logic o, input logic m, input logic e);
    n_vec++;
    if (bus.addr_out !== a || bus.addr_valid !== v || bus.override !== o ||
        bus.misaligned !== m || bus.sel_err !== e) begin
      n_bad++;
      $display("FAIL %s: got addr=%h v=%b ov=%b mis=%b err=%b, want addr=%h v=%b ov=%b mis=%b err=%b",
               name, bus.addr_out, bus.addr_valid, bus.override, bus.misaligned, bus.sel_err,
               a, v, o, m, e);
    end
  endtask

  task automatic drive(input logic ld, input logic rl, input logic er, input logic ea,
                       input logic [1:0] sel, input logic [1:0] sz, input logic [31:0] eaddr);
    bus.load        = ld;
    bus.release_req = rl;
    bus.excpt_req   = er;
    bus.excpt_ack   = ea;
    bus.sel         = sel;
    bus.size        = sz;
    bus.excpt_addr  = eaddr;
  endtask

  vec_t vecs [$];

  function automatic vec_t mk(input logic ld, input logic rl, input logic er, input logic ea,
                              input logic [1:0] sel, input logic [1:0] sz, input logic [31:0] eaddr,
                              input logic [31:0] xa, input logic xv, input logic xo,
                              input logic xm, input logic xe);
    vec_t t;
    t.ld = ld; t.rl = rl; t.er = er; t.ea = ea; t.sel = sel; t.sz = sz; t.eaddr = eaddr;
    t.x_addr = xa; t.x_valid = xv; t.x_ovrd = xo; t.x_mis = xm; t.x_err = xe;
    return t;
  endfunction

  initial begin
    //               ld rl er ea sel    sz     eaddr          addr          v  ov mis err
    vecs.push_back(mk(0, 0, 0, 0, 2'd0, 2'b10, 32'h0,         32'h0000_0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'd1, 2'b10, 32'h0,         32'h0000_1004, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'd2, 2'b10, 32'h0,         32'h0000_2002, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'd2, 2'b01, 32'h0,         32'h0000_2002, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 2'd0, 2'b00, 32'h0000_00FC, 32'h0000_00FC, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'd1, 2'b00, 32'h0,         32'h0000_00FC, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2'd1, 2'b00, 32'h0,         32'h0000_00FC, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 2'd2, 2'b00, 32'h0000_1235, 32'h0000_00FC, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd0, 2'b00, 32'h0,         32'h0000_00FC, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'd3, 2'b10, 32'h0,         32'h0000_0A00, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 2'd2, 2'b01, 32'h0,         32'h0000_2002, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 2'd1, 2'b00, 32'h0,         32'h0000_1004, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2'd1, 2'b00, 32'h0,         32'h0000_1004, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd0, 2'b00, 32'h0,         32'h0000_1004, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2'd0, 2'b00, 32'h0,         32'h0000_1004, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'd0, 2'b11, 32'h0,         32'h0000_0A00, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 2'd1, 2'b01, 32'h0,         32'h0000_1004, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2'd0, 2'b01, 32'h0,         32'h0000_1004, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2'd0, 2'b00, 32'h0000_0102, 32'h0000_0102, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd0, 2'b00, 32'h0,         32'h0000_0102, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2'd0, 2'b00, 32'h0,         32'h0000_0102, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'd2, 2'b00, 32'h0,         32'h0000_2002, 1, 0, 0, 0));

    bus.src_flat = {32'h0000_2002, 32'h0000_1004, 32'h0000_0A00};
    drive(0, 0, 0, 0, 2'd0, 2'b10, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    check("reset", 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].rl, vecs[i].er, vecs[i].ea, vecs[i].sel, vecs[i].sz, vecs[i].eaddr);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].x_addr, vecs[i].x_valid, vecs[i].x_ovrd,
            vecs[i].x_mis, vecs[i].x_err);
    end

    // Enter OVRD, then pull reset mid-cycle: outputs must clear before the next edge.
    drive(1, 0, 1, 0, 2'd1, 2'b00, 32'h0000_00FC);
    @(posedge clk);
    #1;
    check("ovrd_entry", 32'h0000_00FC, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 2'd0, 2'b00, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", 32'h0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("reset_hold", 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // First load after reset behaves as from IDLE; a following release proves HOLD.
    drive(1, 0, 0, 0, 2'd1, 2'b10, 32'h0);
    @(posedge clk);
    #1;
    check("post_reset_load", 32'h0000_1004, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 2'd0, 2'b10, 32'h0);
    @(posedge clk);
    #1;
    check("post_reset_release", 32'h0000_1004, 0, 0, 0, 0);

    // Back-to-back loads every cycle in HOLD.
    drive(1, 0, 0, 0, 2'd0, 2'b00, 32'h0);
    @(posedge clk);
    #1;
    check("b2b_0", 32'h0000_0A00, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 2'd2, 2'b00, 32'h0);
    @(posedge clk);
    #1;
    check("b2b_1", 32'h0000_2002, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 2'd1, 2'b10, 32'h0);
    @(posedge clk);
    #1;
    check("b2b_2", 32'h0000_1004, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
